cacheline_arbiter: RTL and testbench

Two-port arbiter that shares the single cacheline adaptor / physical memory path between the instruction cache (port I) and data cache (port D) in the pipelined processor. It grants one requester at a time with round-robin tie-breaking, forwards the owner's line-level request downstream, and routes the adaptor's response back to the owner. A transaction is never preempted. A one-cycle release gap after every transaction lets the adaptor return to its idle state before the next grant.

---
 rtl/cacheline_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cacheline_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter
//
// Shares the single cacheline adaptor / physical memory path between the
// instruction cache (port I) and the data cache (port D). One requester owns
// the adaptor at a time; simultaneous requests are broken round-robin. A
// granted transaction always runs to the adaptor's m_resp, and every
// transaction is followed by a one-cycle release gap so the adaptor can settle
// back to idle before the next grant.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_address/i_read/i_write/i_wdata   I-cache line request (level)
//   i_rdata/i_resp           read line and one-cycle completion to I-cache
//   d_address/d_read/d_write/d_wdata   D-cache line request (level)
//   d_rdata/d_resp           read line and one-cycle completion to D-cache
//   m_address/m_read/m_write/m_wdata   request to the cacheline adaptor
//   m_rdata/m_resp           read line and completion from the adaptor
//
// The downstream request and the response pulses are combinational functions
// of the registered grant state, so they are zero exactly when the arbiter is
// idle, releasing or held in reset.

module cacheline_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp
);

   typedef enum logic [1:0] {
      StIdle,
      StGrantI,
      StGrantD,
      StRelease
   } state_e;

   typedef enum logic {
      PortI,
      PortD
   } port_e;

   state_e state_q, state_d;
   port_e  last_grant_q, last_grant_d;

   logic req_i;
   logic req_d;

   assign req_i = i_read | i_write;
   assign req_d = d_read | d_write;

   // ------------------------------------------------------------------------
   // Next-state: arbitration in idle, hold the grant until the adaptor
   // completes, then one release cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;

      unique case (state_q)
         StIdle: begin
            if (req_i && req_d) begin
               // Tie: the port that did not win last time goes next.
               if (last_grant_q == PortI) begin
                  state_d      = StGrantD;
                  last_grant_d = PortD;
               end else begin
                  state_d      = StGrantI;
                  last_grant_d = PortI;
               end
            end else if (req_d) begin
               state_d      = StGrantD;
               last_grant_d = PortD;
            end else if (req_i) begin
               state_d      = StGrantI;
               last_grant_d = PortI;
            end
         end

         // The owner may withdraw its request early, but the adaptor has
         // already committed, so only m_resp ends the grant.
         StGrantI: begin
            if (m_resp) begin
               state_d = StRelease;
            end
         end

         StGrantD: begin
            if (m_resp) begin
               state_d = StRelease;
            end
         end

         StRelease: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= PortI;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath: route the owner's live request down and the adaptor's
   // completion back to the owner only.
   // ------------------------------------------------------------------------
   always_comb begin
      m_address = '0;
      m_read    = 1'b0;
      m_write   = 1'b0;
      m_wdata   = '0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;

      unique case (state_q)
         StGrantI: begin
            m_address = i_address;
            m_read    = i_read;
            m_write   = i_write;
            m_wdata   = i_wdata;
            i_resp    = m_resp;
         end

         StGrantD: begin
            m_address = d_address;
            m_read    = d_read;
            m_write   = d_write;
            m_wdata   = d_wdata;
            d_resp    = m_resp;
         end

         default: begin
         end
      endcase
   end

   // Read data is broadcast; each cache qualifies it with its own resp.
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Testbench for cacheline_arbiter.
//
// Each round the bench builds a set of I/D transactions, predicts the order in
// which they must reach the adaptor (earlier requester first, ties to the port
// that did not win last, queued per port in issue order) and pushes that order
// into a scoreboard queue. Requester processes then drive the ports; a
// monitor pops the scoreboard whenever a new downstream request appears and
// checks the request, its grant cycle, the routed response and the release gap.
// A small adaptor model answers each request after a random latency with a
// line derived from the address.

module tb_cacheline_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   typedef struct {
      int           port;   // 0 = I, 1 = D
      logic [AW-1:0] addr;
      logic          rd;
      logic          wr;
      logic [LW-1:0] wdata;
      bit            drop;  // requester withdraws its request mid-grant
   } txn_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic [AW-1:0] i_address, d_address, m_address;
   logic          i_read, i_write, d_read, d_write, m_read, m_write;
   logic [LW-1:0] i_wdata, d_wdata, m_wdata;
   logic [LW-1:0] i_rdata, d_rdata, m_rdata;
   logic          i_resp, d_resp, m_resp;

   logic [AW-1:0] port_addr [2];
   logic          port_rd   [2];
   logic          port_wr   [2];
   logic [LW-1:0] port_wdata[2];

   assign i_address = port_addr[0];
   assign i_read    = port_rd[0];
   assign i_write   = port_wr[0];
   assign i_wdata   = port_wdata[0];
   assign d_address = port_addr[1];
   assign d_read    = port_rd[1];
   assign d_write   = port_wr[1];
   assign d_wdata   = port_wdata[1];

   cacheline_arbiter #(
      .ADDR_W(AW),
      .LINE_W(LW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_address(i_address),
      .i_read   (i_read),
      .i_write  (i_write),
      .i_wdata  (i_wdata),
      .i_rdata  (i_rdata),
      .i_resp   (i_resp),
      .d_address(d_address),
      .d_read   (d_read),
      .d_write  (d_write),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_resp   (d_resp),
      .m_address(m_address),
      .m_read   (m_read),
      .m_write  (m_write),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .m_resp   (m_resp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_tests = 0;
   int   n_fail  = 0;
   txn_t exp_q[$];
   txn_t drv_i[$], drv_d[$];
   txn_t b_i[$], b_d[$];
   int   raise_cyc[2];
   int   last_resp_cyc = -100;
   int   mdl_last = 0;   // port granted last; reset grants the first tie to D
   int   force_lat = 0;

   bit            ad_busy = 1'b0;
   int            ad_cnt  = 0;
   logic [AW-1:0] ad_addr = '0;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
      if (a == 32'h0000_1000) return {8{32'hA5A5_A5A5}};
      return {8{a ^ 32'h3C3C_0F0F}};
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom();
      return l;
   endfunction

   function automatic txn_t rand_txn(input int p, input bit drop);
      txn_t        t;
      logic [31:0] tmp;
      int          r;
      tmp     = $urandom();
      r       = $urandom_range(0, 9);
      t.port  = p;
      t.addr  = tmp & 32'hFFFF_FFE0;
      t.rd    = (r < 6) || (r == 9);
      t.wr    = (r >= 6);
      t.wdata = rand_line();
      t.drop  = drop;
      return t;
   endfunction

   task automatic check_word(input string name, input logic [LW-1:0] act,
                             input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Adaptor model: accepts a request when idle, answers L cycles later.
   // ------------------------------------------------------------------------
   initial begin
      m_resp  = 1'b0;
      m_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         m_resp  = 1'b0;
         m_rdata = rand_line();
         if (ad_busy && !rst) begin
            ad_cnt--;
            if (ad_cnt == 0) begin
               m_resp  = 1'b1;
               m_rdata = line_of(ad_addr);
               ad_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && !ad_busy && !m_resp && (m_read || m_write)) begin
            ad_busy = 1'b1;
            ad_addr = m_address;
            ad_cnt  = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   initial begin
      txn_t own;
      int   owner = 0;
      bit   busy  = 1'b0;
      bit   rel   = 1'b0;
      int   eg;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            rel  = 1'b0;
         end else begin
            check_word("rdata_i_pass", i_rdata, m_rdata);
            check_word("rdata_d_pass", d_rdata, m_rdata);
            if (rel) begin
               rel = 1'b0;
               check_int("release_ctrl", int'({m_read, m_write, i_resp, d_resp}), 0);
               check_word("release_addr", LW'(m_address), '0);
               check_word("release_wdata", m_wdata, '0);
            end else if (!busy) begin
               check_int("idle_resp", int'({i_resp, d_resp}), 0);
               if (m_read || m_write) begin
                  if (exp_q.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL unexpected_grant: got request to %h, required none (cycle %0d)",
                              m_address, cyc);
                  end else begin
                     own = exp_q.pop_front();
                     check_word("grant_addr", LW'(m_address), LW'(own.addr));
                     check_int("grant_op", int'({m_read, m_write}), int'({own.rd, own.wr}));
                     check_word("grant_wdata", m_wdata, own.wdata);
                     eg = raise_cyc[own.port] + 1;
                     if (last_resp_cyc + 3 > eg) eg = last_resp_cyc + 3;
                     check_int("grant_cycle", cyc, eg);
                     busy  = 1'b1;
                     owner = own.port;
                  end
               end
            end else begin
               check_bit("busy_read", m_read, port_rd[owner]);
               check_bit("busy_write", m_write, port_wr[owner]);
               check_word("busy_addr", LW'(m_address), LW'(own.addr));
               if (m_resp) begin
                  check_bit("owner_resp", (owner == 1) ? d_resp : i_resp, 1'b1);
                  check_bit("other_resp", (owner == 1) ? i_resp : d_resp, 1'b0);
                  check_word("owner_rdata", (owner == 1) ? d_rdata : i_rdata, line_of(own.addr));
                  busy          = 1'b0;
                  rel           = 1'b1;
                  last_resp_cyc = cyc;
               end else begin
                  check_int("busy_resp", int'({i_resp, d_resp}), 0);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Requesters: hold a request until resp, drop it for one cycle, repeat.
   // ------------------------------------------------------------------------
   task automatic drive_port(input int p, input int dly);
      txn_t t;
      bit   got;
      int   waitc;
      repeat (dly) begin
         @(posedge clk);
         #1;
      end
      while (((p == 0) ? drv_i.size() : drv_d.size()) > 0) begin
         if (p == 0) t = drv_i.pop_front();
         else        t = drv_d.pop_front();
         port_addr[p]  = t.addr;
         port_wdata[p] = t.wdata;
         port_rd[p]    = t.rd;
         port_wr[p]    = t.wr;
         raise_cyc[p]  = cyc;
         got   = 1'b0;
         waitc = 0;
         while (!got && waitc < 200) begin
            @(negedge clk);
            waitc++;
            if (((p == 0) ? i_resp : d_resp) == 1'b1) begin
               got = 1'b1;
            end else if (t.drop && waitc == 2) begin
               @(posedge clk);
               #1;
               port_rd[p] = 1'b0;
               port_wr[p] = 1'b0;
            end
         end
         n_tests++;
         if (!got) begin
            n_fail++;
            $display("FAIL resp_timeout: port %0d got no resp, required one within 200 cycles", p);
         end
         @(posedge clk);
         #1;
         port_rd[p] = 1'b0;
         port_wr[p] = 1'b0;
         if (((p == 0) ? drv_i.size() : drv_d.size()) > 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Predict grant order for the staged transactions, then run them.
   // offset > 0: port fp raises first, the other port offset cycles later.
   task automatic run_round(input int offset, input int fp);
      txn_t qi[$], qd[$];
      txn_t e;
      int   pick;
      bit   first;
      qi    = b_i;
      qd    = b_d;
      first = 1'b1;
      while (qi.size() > 0 || qd.size() > 0) begin
         if (first && offset > 0 && qi.size() > 0 && qd.size() > 0) pick = fp;
         else if (qi.size() > 0 && qd.size() > 0) pick = (mdl_last == 0) ? 1 : 0;
         else pick = (qi.size() > 0) ? 0 : 1;
         first = 1'b0;
         if (pick == 1) e = qd.pop_front();
         else           e = qi.pop_front();
         exp_q.push_back(e);
         mdl_last = pick;
      end
      drv_i = b_i;
      drv_d = b_d;
      b_i.delete();
      b_d.delete();
      @(posedge clk);
      #1;
      fork
         drive_port(0, (offset > 0 && fp == 1) ? offset : 0);
         drive_port(1, (offset > 0 && fp == 0) ? offset : 0);
      join
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_int("reset_ctrl", int'({m_read, m_write, i_resp, d_resp}), 0);
      check_word("reset_addr", LW'(m_address), '0);
      check_word("reset_wdata", m_wdata, '0);
      ad_busy = 1'b0;
      m_resp  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst           = 1'b0;
      mdl_last      = 0;
      last_resp_cyc = -100;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      txn_t t;
      bit   got;
      for (int p = 0; p < 2; p++) begin
         port_addr[p]  = '0;
         port_rd[p]    = 1'b0;
         port_wr[p]    = 1'b0;
         port_wdata[p] = '0;
         raise_cyc[p]  = 0;
      end

      // D read alone right after reset.
      do_reset();
      t = rand_txn(1, 1'b0);
      t.addr = 32'h0000_1000;
      t.rd   = 1'b1;
      t.wr   = 1'b0;
      b_d.push_back(t);
      run_round(0, 0);

      // Simultaneous I read and D write after reset: D first.
      do_reset();
      t = rand_txn(0, 1'b0);
      t.rd = 1'b1;
      t.wr = 1'b0;
      b_i.push_back(t);
      t = rand_txn(1, 1'b0);
      t.rd = 1'b0;
      t.wr = 1'b1;
      b_d.push_back(t);
      run_round(0, 0);

      // Both ports sustained for four transactions: D, I, D, I.
      for (int k = 0; k < 2; k++) begin
         b_i.push_back(rand_txn(0, 1'b0));
         b_d.push_back(rand_txn(1, 1'b0));
      end
      run_round(0, 0);

      // I withdraws mid-grant while D waits behind it.
      b_i.push_back(rand_txn(0, 1'b1));
      b_d.push_back(rand_txn(1, 1'b0));
      run_round(1, 0);

      // Random rounds.
      for (int r = 0; r < 40; r++) begin
         int mask;
         int offset;
         int fp;
         int ni;
         int nd;
         int dp;
         bit dropping;
         mask   = $urandom_range(1, 3);
         offset = 0;
         fp     = 0;
         if (mask == 3 && $urandom_range(0, 1) == 1) begin
            offset = $urandom_range(1, 3);
            fp     = $urandom_range(0, 1);
         end
         ni = ((mask & 1) != 0) ? int'($urandom_range(1, 2)) : 0;
         nd = ((mask & 2) != 0) ? int'($urandom_range(1, 2)) : 0;
         dp = (mask == 3) ? fp : ((mask == 1) ? 0 : 1);
         dropping = (mask != 3 || offset > 0) && (((dp == 0) ? ni : nd) == 1) &&
                    ($urandom_range(0, 2) == 0);
         for (int k = 0; k < ni; k++) b_i.push_back(rand_txn(0, dropping && dp == 0));
         for (int k = 0; k < nd; k++) b_d.push_back(rand_txn(1, dropping && dp == 1));
         run_round(offset, fp);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Reset while D owns the adaptor, then re-arbitrate the same request.
      t = rand_txn(1, 1'b0);
      t.addr = 32'h0000_2040;
      t.rd   = 1'b1;
      t.wr   = 1'b0;
      @(posedge clk);
      #1;
      force_lat = 20;
      exp_q.push_back(t);
      port_addr[1]  = t.addr;
      port_wdata[1] = t.wdata;
      port_rd[1]    = 1'b1;
      port_wr[1]    = 1'b0;
      raise_cyc[1]  = cyc;
      @(negedge clk);
      @(negedge clk);
      #2;
      check_bit("grant_before_reset", m_read, 1'b1);
      rst = 1'b1;
      #1;
      check_int("midreset_ctrl", int'({m_read, m_write, i_resp, d_resp}), 0);
      check_word("midreset_addr", LW'(m_address), '0);
      check_word("midreset_wdata", m_wdata, '0);
      ad_busy  = 1'b0;
      mdl_last = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      force_lat     = 0;
      rst           = 1'b0;
      last_resp_cyc = -100;
      raise_cyc[1]  = cyc;
      exp_q.push_back(t);
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge clk);
         if (d_resp) got = 1'b1;
      end
      check_bit("rearb_resp_seen", got, 1'b1);
      @(posedge clk);
      #1;
      port_rd[1] = 1'b0;

      repeat (5) @(posedge clk);
      check_int("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1000000, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
